load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory initiator between the CPU execute stage and the 1 KB on-chip
//  byte-lane RAM. Runs RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW accesses.
//  Aligns store data onto byte lanes with an active-low write mask.
//  Extracts, sign-extends or zero-extends load data. Rejects misaligned
//  or illegal accesses without touching memory.
// PARAMETERS
//  ADDR_WIDTH  10  byte-address width driven to the RAM (RAM size = 2**ADDR_WIDTH)
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous reset, active-low
//  start           in   1   one-cycle request strobe; sampled only in IDLE
//  is_store        in   1   1=store, 0=load
//  funct3          in   3   RISC-V funct3 (size in [1:0], unsigned in [2])
//  address         in   32  byte address of the access
//  store_data      in   32  store source (rs2)
//  load_data       out  32  extended load result; held until the next load completes
//  busy            out  1   high from the cycle after start until done
//  done            out  1   one-cycle completion pulse
//  error           out  1   one-cycle pulse with done on misaligned/illegal access
//  mem_address     out  ADDR_WIDTH  to RAM address; bits [1:0] passed through
//  mem_write_data  out  32  to RAM data_in
//  mem_write_mask  out  4   to RAM write_mask; active-low per byte lane
//  mem_write_enable out 1   to RAM write_enable
//  mem_read_data   in   32  from RAM data_out; registered, valid 1 cycle after address
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; load_data=0; busy=done=error=0; mem_write_enable=0.
//   - mem_write_mask=4'hf; mem_address=0; mem_write_data=0.
//  Request latch:
//   - On start in IDLE, latch is_store, funct3, address[ADDR_WIDTH-1:0], store_data.
//   - start while busy is ignored.
//  Illegal access:
//   - load funct3 011/110/111, or store funct3[2]=1 or 011.
//  Misaligned access:
//   - half-word with addr[0]=1, or word with addr[1:0]!=0.
//   - Goes IDLE->FINISH, error=1, no RAM strobe issued.
//  FSM: IDLE -> {LOAD_ADDR | STORE | FINISH}
//   - LOAD_ADDR -> LOAD_DATA -> FINISH -> IDLE; STORE -> FINISH -> IDLE.
//  LOAD_ADDR:
//   - Drive mem_address, mem_write_enable=0.
//   - RAM captures data on this cycle's closing edge.
//  LOAD_DATA:
//   - Sample mem_read_data, select the lane by addr[1:0].
//   - Byte: lane addr[1:0]; half: [15:0] if addr[1]=0, else [31:16].
//   - Extend per funct3[2]: 0=sign, 1=zero. Register into load_data.
//  STORE:
//   - mem_write_enable=1 for exactly one cycle.
//   - Byte: data replicated to all 4 lanes; mask clears lane addr[1:0] only.
//   - Half: data on both halves; mask 4'b1100 (addr[1]=0) or 4'b0011 (addr[1]=1).
//   - Word: mask 4'b0000.
//   - Outside STORE: mem_write_enable=0, mask=4'hf.
//  FINISH: done=1 for one cycle (error as decided); busy drops same cycle.
//  Timing: start sampled at edge 0.
//   - Load: done visible after edge 3.
//   - Store: done visible after edge 2.
//   - Error: done visible after edge 1.
//  Back-to-back: a new start is accepted in the IDLE cycle after FINISH.
//  Reset mid-access:
//   - All outputs return to reset values immediately.
//   - An in-flight store is dropped if reset precedes the STORE edge.
// TESTING
//  - SW addr 0x10 data 0xdeadbeef; then LW 0x10 -> mask 0000 one cycle; load_data=0xdeadbeef, done 3 cycles after start.
//  - SB addr 0x13 data 0x000000a5 -> mask 4'b0111, write_data 0xa5a5a5a5; LB 0x13 -> 0xffffffa5, LBU -> 0x000000a5.
//  - SH addr 0x22 data 0x8001 -> mask 4'b0011; LH 0x22 -> 0xffff8001, LHU -> 0x00008001.
//  - LW addr 0x31, SH addr 0x41 -> done+error 1 cycle after start, write_enable never high.
//  - Illegal funct3 3'b011 load -> done+error pulse; start asserted while busy is ignored.
//  - reset asserted in LOAD_DATA -> busy/done=0, mask=4'hf, load_data=0 without waiting for a clock edge.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW initiator for a byte-lane RAM.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           address,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic [3:0]            mem_write_mask,
  output logic                  mem_write_enable,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_ADDR = 3'd1,
    LOAD_DATA = 3'd2,
    STORE     = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t                r_state;
  logic [2:0]            r_funct3;
  logic                  r_error_pending;
  logic [31:0]           r_load_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_write_data;
  logic [3:0]            r_mem_write_mask;
  logic                  r_mem_write_enable;

  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_reject;
  logic [31:0]           w_store_data;
  logic [3:0]            w_store_mask;
  logic [31:0]           w_lane_data;
  logic [31:0]           w_load_value;
  logic                  w_unused;

  assign w_unused = ^address[31:ADDR_WIDTH];

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    w_illegal    = is_store ? (funct3[2] || funct3[1:0] == 2'b11)
                            : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    w_misaligned = (funct3[1:0] == 2'b01 && address[0]) ||
                   (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
    w_reject     = w_illegal || w_misaligned;
    w_store_data = store_data;
    w_store_mask = 4'b0000;
    case (funct3[1:0])
      2'b00: begin
        w_store_data = {4{store_data[7:0]}};
        w_store_mask = ~(4'b0001 << address[1:0]);
      end
      2'b01: begin
        w_store_data = {2{store_data[15:0]}};
        w_store_mask = address[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  // Load lane selection and extension from the registered RAM word.
  always_comb begin
    w_lane_data = mem_read_data >> {r_mem_address[1:0], 3'b000};
    case (r_funct3[1:0])
      2'b00:   w_load_value = r_funct3[2] ? {24'b0, w_lane_data[7:0]}
                                          : {{24{w_lane_data[7]}}, w_lane_data[7:0]};
      2'b01:   w_load_value = r_funct3[2] ? {16'b0, w_lane_data[15:0]}
                                          : {{16{w_lane_data[15]}}, w_lane_data[15:0]};
      default: w_load_value = mem_read_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= IDLE;
      r_funct3           <= 3'b000;
      r_error_pending    <= 1'b0;
      r_load_data        <= 32'h0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_error            <= 1'b0;
      r_mem_address      <= '0;
      r_mem_write_data   <= 32'h0;
      r_mem_write_mask   <= 4'hf;
      r_mem_write_enable <= 1'b0;
    end else begin
      r_done             <= 1'b0;
      r_error            <= 1'b0;
      r_mem_write_enable <= 1'b0;
      r_mem_write_mask   <= 4'hf;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_funct3        <= funct3;
            r_mem_address   <= address[ADDR_WIDTH-1:0];
            r_error_pending <= w_reject;
            r_busy          <= 1'b1;
            if (w_reject) begin
              r_state <= FINISH;
            end else if (is_store) begin
              r_state            <= STORE;
              r_mem_write_enable <= 1'b1;
              r_mem_write_data   <= w_store_data;
              r_mem_write_mask   <= w_store_mask;
            end else begin
              r_state <= LOAD_ADDR;
            end
          end
        end
        LOAD_ADDR: r_state <= LOAD_DATA;
        LOAD_DATA: begin
          r_load_data <= w_load_value;
          r_state     <= FINISH;
        end
        STORE:     r_state <= FINISH;
        FINISH: begin
          r_done  <= 1'b1;
          r_error <= r_error_pending;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default:   r_state <= IDLE;
      endcase
    end
  end

  assign load_data        = r_load_data;
  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;
  assign mem_address      = r_mem_address;
  assign mem_write_data   = r_mem_write_data;
  assign mem_write_mask   = r_mem_write_mask;
  assign mem_write_enable = r_mem_write_enable;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit with a byte-lane RAM model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_ld;
  logic        ram_clear;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .is_store         (is_store),
    .funct3           (funct3),
    .address          (address),
    .store_data       (store_data),
    .load_data        (load_data),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_mask   (mem_write_mask),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane RAM with registered read and active-low write mask.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    end else if (mem_write_enable) begin
      for (int l = 0; l < 4; l++)
        if (!mem_write_mask[l]) ram[{mem_address[9:2], l[1:0]}] <= mem_write_data[8*l +: 8];
    end
    mem_read_data <= {ram[{mem_address[9:2], 2'd3}], ram[{mem_address[9:2], 2'd2}],
                      ram[{mem_address[9:2], 2'd1}], ram[{mem_address[9:2], 2'd0}]};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and RISC-V access rules.
  task automatic model_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic e_err, output int e_lat,
                          output int e_we, output logic [3:0] e_mask, output logic [31:0] e_wdata);
    int n;
    logic legal;
    logic [31:0] v;
    n     = 1 << f3[1:0];
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_err = !legal || ((a % n) != 0);
    e_we = 0; e_mask = 4'hf; e_wdata = 32'h0;
    if (e_err) begin
      e_lat = 1;
    end else if (st) begin
      e_lat = 2; e_we = 1;
      for (int i = 0; i < n; i++) begin
        e_mask[(a + i) % 4]     = 1'b0;
        ref_mem[(a + i) % 1024] = d[8*i +: 8];
      end
      e_wdata = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
    end else begin
      e_lat = 3; v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 1024]) << (8*i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hffffffff << (8*n));
      exp_ld = v;
    end
  endtask

  // Issue one request and observe it until done (bounded).
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic err,
                        output int we_cnt, output int busy_cnt, output logic [3:0] mask,
                        output logic [31:0] wdata, output logic busy_end);
    is_store = st; funct3 = f3; address = a; store_data = d; start = 1'b1;
    lat = 0; err = 1'b0; we_cnt = 0; busy_cnt = 0; mask = 4'hf; wdata = 32'h0; busy_end = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      lat = k;
      if (mem_write_enable) begin
        we_cnt++; mask = mem_write_mask; wdata = mem_write_data;
      end
      if (done) begin
        err = error; busy_end = busy;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
    logic e_err, err, busy_end;
    int e_lat, e_we, lat, we_cnt, busy_cnt;
    logic [3:0] e_mask, mask;
    logic [31:0] e_wdata, wdata;
    model_op(st, f3, a, d, e_err, e_lat, e_we, e_mask, e_wdata);
    run_op(st, f3, a, d, lat, err, we_cnt, busy_cnt, mask, wdata, busy_end);
    chk({tag, " latency"}, lat, e_lat);
    chk({tag, " error"}, err, e_err);
    chk({tag, " write pulses"}, we_cnt, e_we);
    chk({tag, " busy cycles"}, busy_cnt, e_lat);
    chk({tag, " busy at done"}, busy_end, 1'b0);
    if (e_we != 0) begin
      chk({tag, " mask"}, mask, e_mask);
      chk({tag, " wdata"}, wdata, e_wdata);
    end
    chk({tag, " load_data"}, load_data, exp_ld);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  vec_t        tbl [11];
  logic        t_err, t_err_seen, t_busy_end;
  int          t_lat, t_we, t_lat_seen, t_we_cnt, t_busy_cnt;
  logic [3:0]  t_mask, t_mask_seen;
  logic [31:0] t_wdata, t_wdata_seen;
  int          sq_lat, sq_we, sq_done;

  initial begin
    tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'hdeadbeef, 1'b0, 4'b0000, 32'hdeadbeef, 32'h00000000};
    tbl[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 4'hf,    32'h0,        32'hdeadbeef};
    tbl[2]  = '{1'b1, 3'b000, 32'h13, 32'h000000a5, 1'b0, 4'b0111, 32'ha5a5a5a5, 32'hdeadbeef};
    tbl[3]  = '{1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 4'hf,    32'h0,        32'hffffffa5};
    tbl[4]  = '{1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 4'hf,    32'h0,        32'h000000a5};
    tbl[5]  = '{1'b1, 3'b001, 32'h22, 32'h00008001, 1'b0, 4'b0011, 32'h80018001, 32'h000000a5};
    tbl[6]  = '{1'b0, 3'b001, 32'h22, 32'h0,        1'b0, 4'hf,    32'h0,        32'hffff8001};
    tbl[7]  = '{1'b0, 3'b101, 32'h22, 32'h0,        1'b0, 4'hf,    32'h0,        32'h00008001};
    tbl[8]  = '{1'b0, 3'b010, 32'h31, 32'h0,        1'b1, 4'hf,    32'h0,        32'h00008001};
    tbl[9]  = '{1'b1, 3'b001, 32'h41, 32'h1234,     1'b1, 4'hf,    32'h0,        32'h00008001};
    tbl[10] = '{1'b0, 3'b011, 32'h20, 32'h0,        1'b1, 4'hf,    32'h0,        32'h00008001};

    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    address = 32'h0; store_data = 32'h0; ram_clear = 1'b1; exp_ld = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    #2 reset = 1'b0;
    #1;
    chk("reset load_data", load_data, 32'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset error", error, 1'b0);
    chk("reset write_enable", mem_write_enable, 1'b0);
    chk("reset mask", mem_write_mask, 4'hf);
    chk("reset mem_address", mem_address, 10'h0);
    chk("reset write_data", mem_write_data, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; ram_clear = 1'b0;

    for (int i = 0; i < 11; i++) begin
      model_op(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, t_err, t_lat, t_we, t_mask, t_wdata);
      run_op(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, t_lat_seen, t_err_seen, t_we_cnt,
             t_busy_cnt, t_mask_seen, t_wdata_seen, t_busy_end);
      exp_ld = tbl[i].ld;
      chk($sformatf("vec%0d latency", i), t_lat_seen, tbl[i].err ? 1 : (tbl[i].st ? 2 : 3));
      chk($sformatf("vec%0d error", i), t_err_seen, tbl[i].err);
      chk($sformatf("vec%0d write pulses", i), t_we_cnt, (tbl[i].st && !tbl[i].err) ? 1 : 0);
      if (tbl[i].st && !tbl[i].err) begin
        chk($sformatf("vec%0d mask", i), t_mask_seen, tbl[i].mask);
        chk($sformatf("vec%0d wdata", i), t_wdata_seen, tbl[i].wdata);
      end
      chk($sformatf("vec%0d load_data", i), load_data, tbl[i].ld);
    end

    // A start pulse held through the busy window must not launch a second access.
    model_op(1'b0, 3'b010, 32'h10, 32'h0, t_err, t_lat, t_we, t_mask, t_wdata);
    is_store = 1'b0; funct3 = 3'b010; address = 32'h10; start = 1'b1;
    sq_lat = -1; sq_we = 0; sq_done = 0;
    @(posedge clk); #1;
    is_store = 1'b1; address = 32'h44; store_data = 32'h12345678;
    for (int k = 0; k < 8; k++) begin
      if (mem_write_enable) sq_we++;
      if (done) begin
        sq_done++;
        if (sq_lat < 0) sq_lat = k;
      end
      if (k == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy-start latency", sq_lat, 3);
    chk("busy-start done count", sq_done, 1);
    chk("busy-start write pulses", sq_we, 0);
    chk("busy-start load_data", load_data, exp_ld);

    for (int i = 0; i < 400; i++) begin
      logic        r_st;
      logic [2:0]  r_f3;
      logic [31:0] r_a;
      r_st = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = ($urandom & 32'hfffffc00) | 32'($urandom_range(0, 63));
      check_op($sformatf("rand%0d", i), r_st, r_f3, r_a, $urandom);
    end

    // Reset while the load is in LOAD_DATA.
    check_op("pre-reset LW", 1'b0, 3'b010, 32'h10, 32'h0);
    is_store = 1'b0; funct3 = 3'b010; address = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid-reset busy before", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid-reset busy", busy, 1'b0);
    chk("mid-reset done", done, 1'b0);
    chk("mid-reset error", error, 1'b0);
    chk("mid-reset mask", mem_write_mask, 4'hf);
    chk("mid-reset load_data", load_data, 32'h0);
    chk("mid-reset mem_address", mem_address, 10'h0);
    exp_ld = 32'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_op("post-reset LW", 1'b0, 3'b010, 32'h10, 32'h0);

    // Reset during the STORE cycle drops the write.
    is_store = 1'b1; funct3 = 3'b010; address = 32'h50; store_data = 32'hcafef00d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("drop store write_enable before", mem_write_enable, 1'b1);
    chk("drop store mask before", mem_write_mask, 4'b0000);
    reset = 1'b0;
    #1;
    chk("drop store write_enable", mem_write_enable, 1'b0);
    chk("drop store mask", mem_write_mask, 4'hf);
    @(posedge clk); #1;
    reset = 1'b1;
    check_op("dropped SW readback", 1'b0, 3'b010, 32'h50, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
